// File: rtl/excp_tmr_ctrl_pkg.sv
// Shared definitions for the machine-timer access sequencer:
// register-half width, request select encodings, the mtimecmp park value
// and the sequencer state encoding.
package excp_tmr_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic SEL_MTIME    = 1'b0;
    localparam logic SEL_MTIMECMP = 1'b1;

    // Low half of mtimecmp is parked here while the high half changes, so
    // the compare can never match an intermediate value.
    localparam logic [XLEN-1:0] MTIMECMP_PARK = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_H0 = 3'd1,
        ST_RD_L  = 3'd2,
        ST_RD_H1 = 3'd3,
        ST_WR_L0 = 3'd4,
        ST_WR_H  = 3'd5,
        ST_WR_L1 = 3'd6,
        ST_RESP  = 3'd7
    } tmr_state_e;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/excp_tmr_ctrl_rr_arb.sv
// Two-way round-robin arbiter. Grants only while enabled; the pointer
// moves to the requester that was not just served when advance is high.
module excp_tmr_rr_arb
    import excp_tmr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       adv,
    input  logic       adv_id,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr_q;

    // Priority pointer: favour the other requester after each completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (adv) begin
            ptr_q <= ~adv_id;
        end
    end

    // Pick the pointed-to requester first, else the other one.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = ptr_q;
        if (en && req[ptr_q]) begin
            gnt_id = ptr_q;
            gnt    = id_onehot(ptr_q);
        end else if (en && req[~ptr_q]) begin
            gnt_id = ~ptr_q;
            gnt    = id_onehot(~ptr_q);
        end
    end

endmodule

// File: rtl/excp_tmr_ctrl.sv
// Sequencer in front of the 32-bit mtime/mtimecmp register port. Takes
// 64-bit requests from LSU (0) and debug (1), arbitrates round-robin and
// splits each request into ordered half-register port cycles, with
// tear-free mtime reads and glitch-free mtimecmp writes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | arbitrate, capture grantee's request
// RD_H0    | read high half (mtime or mtimecmp) into h0
// RD_L     | read low half into lo
// RD_H1    | re-read mtime high; equal -> done, else retry from RD_L
// WR_L0    | park mtimecmp low at all-ones
// WR_H     | write mtimecmp high
// WR_L1    | write mtimecmp low
// RESP     | one-cycle completion pulse to the grantee
module excp_tmr_ctrl
    import excp_tmr_ctrl_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wr,
    input  logic [1:0]          req_sel,
    input  logic [4*XLEN-1:0]   req_wdata,
    output logic [1:0]          resp_valid,
    output logic                resp_err,
    output logic [2*XLEN-1:0]   resp_rdata,
    output logic                mtimecmp_wen,
    output logic                mtimecmp_ren,
    output logic                mtime_ren,
    output logic                mreg_hl,
    output logic [XLEN-1:0]     mreg_wdata,
    input  logic [XLEN-1:0]     mreg_rdata,
    input  logic                mreg_ready
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    tmr_state_e state_q, state_d;

    logic               gnt_id_q;
    logic               sel_q;
    logic [2*XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]    h0_q;
    logic [XLEN-1:0]    lo_q;
    logic [RETRY_W-1:0] retry_q;
    logic               err_q;
    logic [2*XLEN-1:0]  rdata_q;

    logic [1:0]         gnt;
    logic               gnt_id;
    logic               arb_en;
    logic               arb_adv;
    logic               req_wr_g;
    logic               req_sel_g;
    logic [2*XLEN-1:0]  req_wdata_g;
    logic               hi_match;
    logic               retry_done;

    // No grants while reset is held, so req_ready stays low in reset.
    assign arb_en  = (state_q == ST_IDLE) && !rst;
    assign arb_adv = (state_q == ST_RESP);

    excp_tmr_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .adv    (arb_adv),
        .adv_id (gnt_id_q),
        .req    (req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready   = gnt;
    assign req_wr_g    = req_wr[gnt_id];
    assign req_sel_g   = req_sel[gnt_id];
    assign req_wdata_g = gnt_id ? req_wdata[4*XLEN-1:2*XLEN] : req_wdata[2*XLEN-1:0];

    assign hi_match   = (mreg_rdata == h0_q);
    assign retry_done = (retry_q == RETRY_LIMIT);
    assign resp_rdata = rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and port/response outputs; each port cycle is held until mreg_ready.
    always_comb begin
        state_d      = state_q;
        mtime_ren    = 1'b0;
        mtimecmp_ren = 1'b0;
        mtimecmp_wen = 1'b0;
        mreg_hl      = 1'b0;
        mreg_wdata   = '0;
        resp_valid   = 2'b00;
        resp_err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    if (!req_wr_g) begin
                        state_d = ST_RD_H0;
                    end else if (req_sel_g == SEL_MTIMECMP) begin
                        state_d = ST_WR_L0;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RD_H0: begin
                mtime_ren    = (sel_q == SEL_MTIME);
                mtimecmp_ren = (sel_q == SEL_MTIMECMP);
                mreg_hl      = 1'b1;
                if (mreg_ready) begin
                    state_d = ST_RD_L;
                end
            end
            ST_RD_L: begin
                mtime_ren    = (sel_q == SEL_MTIME);
                mtimecmp_ren = (sel_q == SEL_MTIMECMP);
                if (mreg_ready) begin
                    state_d = (sel_q == SEL_MTIMECMP) ? ST_RESP : ST_RD_H1;
                end
            end
            ST_RD_H1: begin
                mtime_ren = 1'b1;
                mreg_hl   = 1'b1;
                if (mreg_ready) begin
                    state_d = (hi_match || retry_done) ? ST_RESP : ST_RD_L;
                end
            end
            ST_WR_L0: begin
                mtimecmp_wen = 1'b1;
                mreg_wdata   = MTIMECMP_PARK;
                if (mreg_ready) begin
                    state_d = ST_WR_H;
                end
            end
            ST_WR_H: begin
                mtimecmp_wen = 1'b1;
                mreg_hl      = 1'b1;
                mreg_wdata   = wdata_q[2*XLEN-1:XLEN];
                if (mreg_ready) begin
                    state_d = ST_WR_L1;
                end
            end
            ST_WR_L1: begin
                mtimecmp_wen = 1'b1;
                mreg_wdata   = wdata_q[XLEN-1:0];
                if (mreg_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = id_onehot(gnt_id_q);
                resp_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, read-half collection, retry tracking and response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id_q <= 1'b0;
            sel_q    <= 1'b0;
            wdata_q  <= '0;
            h0_q     <= '0;
            lo_q     <= '0;
            retry_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        gnt_id_q <= gnt_id;
                        sel_q    <= req_sel_g;
                        wdata_q  <= req_wdata_g;
                        retry_q  <= '0;
                        // mtime is read-only: a write is rejected without port cycles.
                        err_q    <= req_wr_g && (req_sel_g == SEL_MTIME);
                    end
                end
                ST_RD_H0: begin
                    if (mreg_ready) begin
                        h0_q <= mreg_rdata;
                    end
                end
                ST_RD_L: begin
                    if (mreg_ready) begin
                        lo_q <= mreg_rdata;
                        if (sel_q == SEL_MTIMECMP) begin
                            rdata_q <= {h0_q, mreg_rdata};
                        end
                    end
                end
                ST_RD_H1: begin
                    if (mreg_ready) begin
                        if (hi_match) begin
                            rdata_q <= {h0_q, lo_q};
                        end else if (retry_done) begin
                            err_q   <= 1'b1;
                            rdata_q <= {mreg_rdata, lo_q};
                        end else begin
                            // High half rolled over: the new value becomes the reference.
                            h0_q    <= mreg_rdata;
                            retry_q <= retry_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excp_tmr_ctrl.sv
// Bench for excp_tmr_ctrl: a small mtime/mtimecmp register environment,
// a transaction-level model of the expected port cycles and responses,
// a per-cycle compare, and directed scenarios with literal expectations.
module tb_excp_tmr_ctrl;

    localparam int MAXR = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [1:0]   req_wr = 2'b00;
    logic [1:0]   req_sel = 2'b00;
    logic [127:0] req_wdata = '0;
    logic [1:0]   resp_valid;
    logic         resp_err;
    logic [63:0]  resp_rdata;
    logic         mtimecmp_wen;
    logic         mtimecmp_ren;
    logic         mtime_ren;
    logic         mreg_hl;
    logic [31:0]  mreg_wdata;
    logic [31:0]  mreg_rdata;
    logic         mreg_ready;

    excp_tmr_ctrl #(.MAX_RETRY(MAXR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_sel      (req_sel),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mtimecmp_wen (mtimecmp_wen),
        .mtimecmp_ren (mtimecmp_ren),
        .mtime_ren    (mtime_ren),
        .mreg_hl      (mreg_hl),
        .mreg_wdata   (mreg_wdata),
        .mreg_rdata   (mreg_rdata),
        .mreg_ready   (mreg_ready)
    );

    always #5 clk = ~clk;

    // ---------------- register environment ----------------
    logic [31:0] hi_seq [0:63];
    logic [31:0] lo_seq [0:63];
    int          hi_i = 0;
    int          lo_i = 0;
    logic [31:0] cmp_hi = '0;
    logic [31:0] cmp_lo = '0;
    int          stall_req = 0;
    int          stall_done = 0;

    assign mreg_ready = !(mtimecmp_wen && mreg_hl && (stall_done < stall_req));
    assign mreg_rdata = mtime_ren    ? (mreg_hl ? hi_seq[hi_i] : lo_seq[lo_i]) :
                        mtimecmp_ren ? (mreg_hl ? cmp_hi : cmp_lo) : 32'h0;

    always @(posedge clk) begin
        if (mtime_ren && mreg_ready) begin
            if (mreg_hl) hi_i <= hi_i + 1;
            else         lo_i <= lo_i + 1;
        end
        if (mtimecmp_wen && mreg_ready) begin
            if (mreg_hl) cmp_hi <= mreg_wdata;
            else         cmp_lo <= mreg_wdata;
        end
        if (mtimecmp_wen && mreg_hl && !mreg_ready) stall_done <= stall_done + 1;
    end

    // ---------------- transaction model ----------------
    logic [1:0]  op_kind [0:255];   // 1 mtime read, 2 mtimecmp read, 3 mtimecmp write
    logic        op_hl   [0:255];
    logic [31:0] op_wd   [0:255];
    int          ohead = 0, otail = 0;
    logic        r_id   [0:31];
    logic        r_err  [0:31];
    logic        r_rd   [0:31];
    logic [63:0] r_data [0:31];
    int          rhead = 0, rtail = 0;

    logic        mptr = 1'b0;
    logic [63:0] last_rdata = '0;
    logic [63:0] last_seen = '0;
    logic        last_err = 1'b0;
    logic [1:0]  acc_seen = 2'b00;
    int          cyc = 0, acc_cyc = 0, nresp = 0, last_lat = 0;
    int          vectors = 0, miscompares = 0;

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_op(input logic [1:0] k, input logic hl, input logic [31:0] wd);
        op_kind[otail] = k;
        op_hl[otail]   = hl;
        op_wd[otail]   = wd;
        otail++;
    endtask

    task automatic push_resp(input logic id, input logic err, input logic rd, input logic [63:0] d);
        r_id[rtail]   = id;
        r_err[rtail]  = err;
        r_rd[rtail]   = rd;
        r_data[rtail] = d;
        rtail++;
    endtask

    // Expected port cycles and response for a request accepted now.
    task automatic model_accept(input logic id);
        logic        wr;
        logic        sel;
        logic [63:0] wd;
        logic [31:0] h0, h1, lo;
        int          k, r;
        wr  = req_wr[id];
        sel = req_sel[id];
        wd  = id ? req_wdata[127:64] : req_wdata[63:0];
        if (wr && !sel) begin
            push_resp(id, 1'b1, 1'b0, 64'h0);
        end else if (wr) begin
            push_op(2'd3, 1'b0, 32'hFFFF_FFFF);
            push_op(2'd3, 1'b1, wd[63:32]);
            push_op(2'd3, 1'b0, wd[31:0]);
            push_resp(id, 1'b0, 1'b0, 64'h0);
        end else if (sel) begin
            push_op(2'd2, 1'b1, 32'h0);
            push_op(2'd2, 1'b0, 32'h0);
            push_resp(id, 1'b0, 1'b1, {cmp_hi, cmp_lo});
        end else begin
            push_op(2'd1, 1'b1, 32'h0);
            h0 = hi_seq[hi_i];
            k  = 0;
            r  = 0;
            while (1) begin
                push_op(2'd1, 1'b0, 32'h0);
                push_op(2'd1, 1'b1, 32'h0);
                lo = lo_seq[lo_i + k];
                h1 = hi_seq[hi_i + 1 + k];
                if (h1 == h0) begin
                    push_resp(id, 1'b0, 1'b1, {h0, lo});
                    break;
                end
                if (r == MAXR) begin
                    push_resp(id, 1'b1, 1'b1, {h1, lo});
                    break;
                end
                h0 = h1;
                r++;
                k++;
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    task automatic check();
        int         ns;
        logic [1:0] k;
        logic [63:0] ed;
        if (rst) begin
            ohead      = otail;
            rhead      = rtail;
            mptr       = 1'b0;
            last_rdata = '0;
        end
        ns = int'(mtime_ren) + int'(mtimecmp_ren) + int'(mtimecmp_wen);
        cmp("strobes_exclusive", 64'(ns > 1), 64'h0);
        cmp("req_ready_onehot", 64'(req_ready == 2'b11), 64'h0);
        if (req_ready != 2'b00) begin
            cmp("grant", 64'(req_ready), 64'(req_valid[mptr] ? oh(mptr) : oh(!mptr)));
            acc_seen = acc_seen | req_ready;
            acc_cyc  = cyc;
            model_accept(req_ready[1]);
        end
        if (ns != 0) begin
            if (ohead == otail) begin
                cmp("unexpected_port_op", 64'(ns), 64'h0);
            end else begin
                k = mtimecmp_wen ? 2'd3 : (mtimecmp_ren ? 2'd2 : 2'd1);
                cmp("op_kind", 64'(k), 64'(op_kind[ohead]));
                cmp("op_hl", 64'(mreg_hl), 64'(op_hl[ohead]));
                if (k == 2'd3) cmp("op_wdata", 64'(mreg_wdata), 64'(op_wd[ohead]));
                if (mreg_ready) ohead++;
            end
        end
        if (resp_valid != 2'b00) begin
            if (rhead == rtail) begin
                cmp("unexpected_resp", 64'(resp_valid), 64'h0);
            end else begin
                ed = r_rd[rhead] ? r_data[rhead] : last_rdata;
                cmp("resp_valid", 64'(resp_valid), 64'(oh(r_id[rhead])));
                cmp("resp_err", 64'(resp_err), 64'(r_err[rhead]));
                cmp("resp_rdata", resp_rdata, ed);
                cmp("ops_drained", 64'(otail - ohead), 64'h0);
                last_rdata = ed;
                mptr       = !r_id[rhead];
                rhead++;
            end
            nresp++;
            last_lat  = cyc - acc_cyc;
            last_err  = resp_err;
            last_seen = resp_rdata;
        end else begin
            cmp("err_without_valid", 64'(resp_err), 64'h0);
            cmp("rdata_held", resp_rdata, last_rdata);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic id, input logic wr, input logic sel,
                           input logic [63:0] wd, input int lat);
        int n0;
        n0 = nresp;
        acc_seen = 2'b00;
        req_wr[id]  = wr;
        req_sel[id] = sel;
        if (id) req_wdata[127:64] = wd;
        else    req_wdata[63:0]   = wd;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 60 && nresp == n0; i++) begin
            tick();
            if (acc_seen[id]) begin
                req_valid[id] = 1'b0;
                acc_seen[id]  = 1'b0;
            end
        end
        req_valid[id] = 1'b0;
        cmp("resp_timeout", 64'(nresp == n0), 64'h0);
        cmp("latency", 64'(last_lat), 64'(lat));
    endtask

    initial begin
        int first, second, n0;
        // reset values, with requests pending while reset is held
        req_valid = 2'b11;
        tick();
        tick();
        cmp("rst_req_ready", 64'(req_ready), 64'h0);
        cmp("rst_resp_valid", 64'(resp_valid), 64'h0);
        cmp("rst_resp_err", 64'(resp_err), 64'h0);
        cmp("rst_resp_rdata", resp_rdata, 64'h0);
        cmp("rst_strobes", 64'({mtime_ren, mtimecmp_ren, mtimecmp_wen}), 64'h0);
        cmp("rst_hl", 64'(mreg_hl), 64'h0);
        cmp("rst_wdata", 64'(mreg_wdata), 64'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // stable mtime read
        hi_seq[hi_i] = 32'h1; hi_seq[hi_i + 1] = 32'h1;
        lo_seq[lo_i] = 32'h10;
        run_one(1'b0, 1'b0, 1'b0, 64'h0, 4);
        cmp("t1_rdata", last_seen, 64'h0000_0001_0000_0010);
        cmp("t1_err", 64'(last_err), 64'h0);

        // rollover between hi and re-check: one retry
        hi_seq[hi_i] = 32'h1; hi_seq[hi_i + 1] = 32'h2; hi_seq[hi_i + 2] = 32'h2;
        lo_seq[lo_i] = 32'h2; lo_seq[lo_i + 1] = 32'h5;
        run_one(1'b0, 1'b0, 1'b0, 64'h0, 6);
        cmp("t2_rdata", last_seen, 64'h0000_0002_0000_0005);
        cmp("t2_err", 64'(last_err), 64'h0);

        // hi changes on every read: error after MAX_RETRY retries
        for (int i = 0; i < 5; i++) hi_seq[hi_i + i] = 32'(10 + i);
        for (int i = 0; i < 4; i++) lo_seq[lo_i + i] = 32'(10 + i);
        run_one(1'b0, 1'b0, 1'b0, 64'h0, 10);
        cmp("t3_err", 64'(last_err), 64'h1);
        cmp("t3_rdata", last_seen, 64'h0000_000E_0000_000D);

        // mtimecmp write from debug, then read back from LSU
        run_one(1'b1, 1'b1, 1'b1, 64'h0000_0005_0000_0100, 4);
        cmp("t4_err", 64'(last_err), 64'h0);
        run_one(1'b0, 1'b0, 1'b1, 64'h0, 3);
        cmp("t5_rdata", last_seen, 64'h0000_0005_0000_0100);

        // port stalls 3 cycles in WR_H
        stall_req = stall_done + 3;
        run_one(1'b1, 1'b1, 1'b1, 64'h0000_0007_0000_0200, 7);

        // illegal write to mtime
        run_one(1'b0, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 1);
        cmp("t7_err", 64'(last_err), 64'h1);
        cmp("t7_rdata_kept", last_seen, 64'h0000_0005_0000_0100);

        // simultaneous requests from reset, twice
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int rep = 0; rep < 2; rep++) begin
            first = -1; second = -1;
            n0 = nresp;
            acc_seen = 2'b00;
            req_wr = 2'b00; req_sel = 2'b11;
            req_valid = 2'b11;
            for (int i = 0; i < 60 && nresp < n0 + 2; i++) begin
                tick();
                for (int b = 0; b < 2; b++) begin
                    if (acc_seen[b]) begin
                        req_valid[b] = 1'b0;
                        acc_seen[b]  = 1'b0;
                        if (first < 0) first = b; else second = b;
                    end
                end
            end
            req_valid = 2'b00;
            cmp("rr_first", 64'(first), 64'h0);
            cmp("rr_second", 64'(second), 64'h1);
        end

        // reset while mtimecmp high half is being written
        acc_seen = 2'b00;
        req_wr[1] = 1'b1; req_sel[1] = 1'b1;
        req_wdata[127:64] = 64'h0000_0009_0000_0300;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 20 && !(mtimecmp_wen && mreg_hl); i++) begin
            tick();
            if (acc_seen[1]) begin
                req_valid[1] = 1'b0;
                acc_seen[1]  = 1'b0;
            end
        end
        req_valid[1] = 1'b0;
        cmp("reached_wr_h", 64'(mtimecmp_wen && mreg_hl), 64'h1);
        n0 = nresp;
        rst = 1'b1;
        #1;
        cmp("abort_strobes", 64'({mtime_ren, mtimecmp_ren, mtimecmp_wen}), 64'h0);
        cmp("abort_hl", 64'(mreg_hl), 64'h0);
        cmp("abort_resp", 64'(resp_valid), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        cmp("abort_no_resp", 64'(nresp - n0), 64'h0);
        // low was parked, high never landed
        run_one(1'b0, 1'b0, 1'b1, 64'h0, 3);
        cmp("abort_cmp_value", last_seen, 64'h0000_0007_FFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
